// File: rtl/clk_meas_pkg.sv
// Shared types and default sizing for the clock period meter.
// Imported by the synchronizer and the measurement top level.
package clk_meas_pkg;

  localparam int unsigned CNT_W_DEF       = 20;
  localparam int unsigned SYNC_STAGES_DEF = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2
  } meas_state_e;

endpackage : clk_meas_pkg

// File: rtl/sync_rise_det.sv
// Brings an asynchronous slow clock into the clk domain and flags its rising edges.
// rise is a one-cycle pulse decoded from the synchronized level and its delayed copy.
module sync_rise_det
  import clk_meas_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;
  logic                   s_d_q;
  logic                   s_d_d;

  // Shift chain: stage 0 samples the async input, top stage is the clean level
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
    s_d_d  = sync_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= sync_d;
      s_d_q  <= s_d_d;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = sync_q[SYNC_STAGES-1] & ~s_d_q;

endmodule : sync_rise_det

// File: rtl/clk_period_meter.sv
// Measures the period of a slow asynchronous clock in clk cycles and reports
// lock / timeout status. Counter saturates at MAX and never wraps.
module clk_period_meter
  import clk_meas_pkg::*;
#(
  parameter int unsigned CNT_W       = CNT_W_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clk_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic unused_sync_level;
  logic rise;

  meas_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;

  sync_rise_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_rise_det (
    .clk    (clk),
    .reset  (reset),
    .d_async(clk_in),
    .s      (unused_sync_level),
    .rise   (rise)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      cnt_q          <= CNT_ZERO;
      period_q       <= CNT_ZERO;
      period_valid_q <= 1'b0;
      locked_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      locked_q       <= locked_d;
      timeout_q      <= timeout_d;
    end
  end

  // Next-state and output logic; disabling overrides every state
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    locked_d       = locked_q;
    timeout_d      = timeout_q;

    if (!en) begin
      state_d   = IDLE;
      cnt_d     = CNT_ZERO;
      locked_d  = 1'b0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d   = ARM;
          cnt_d     = CNT_ZERO;
          locked_d  = 1'b0;
          timeout_d = 1'b0;
        end
        ARM: begin
          if (rise) begin
            cnt_d   = CNT_ONE;
            state_d = MEAS;
          end
        end
        MEAS: begin
          // A rise at the saturation point still counts as a valid period
          if (rise) begin
            period_d       = cnt_q;
            period_valid_d = 1'b1;
            cnt_d          = CNT_ONE;
            locked_d       = 1'b1;
            timeout_d      = 1'b0;
          end else if (cnt_q == CNT_MAX) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            cnt_d     = CNT_ZERO;
            state_d   = ARM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign locked       = locked_q;
  assign timeout      = timeout_q;

endmodule : clk_period_meter

// File: tb/tb_clk_period_meter.sv
// Directed bench for clk_period_meter with a 6-bit counter (MAX = 63).
// A background generator drives clk_in; rate changes take effect at the next rising edge.
module tb_clk_period_meter;

  localparam int unsigned TB_CNT_W = 6;

  logic                clk;
  logic                reset;
  logic                en;
  logic                clk_in;
  logic [TB_CNT_W-1:0] period;
  logic                period_valid;
  logic                locked;
  logic                timeout;

  int n_checks = 0;
  int n_errors = 0;

  bit gen_on    = 1'b0;
  bit gen_level = 1'b0;
  int gen_hi    = 4;
  int gen_lo    = 4;
  int cur_hi    = 4;
  int cur_lo    = 4;
  int ph        = 0;

  int n;
  bit found;
  bit tos;
  int first_to;
  bit saw_valid;
  int guard;

  clk_period_meter #(
    .CNT_W      (TB_CNT_W),
    .SYNC_STAGES(2)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .clk_in      (clk_in),
    .period      (period),
    .period_valid(period_valid),
    .locked      (locked),
    .timeout     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // clk_in generator: hi/lo lengths latched at the start of each period
  initial begin
    clk_in = 1'b0;
    forever begin
      @(negedge clk);
      if (!gen_on) begin
        clk_in = gen_level;
        ph     = 0;
      end else begin
        if (ph == 0) begin
          cur_hi = gen_hi;
          cur_lo = gen_lo;
        end
        clk_in = (ph < cur_hi);
        ph++;
        if (ph >= cur_hi + cur_lo) ph = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Waits for the next period_valid pulse, bounded; also notes whether timeout was seen
  task automatic wait_valid(input int max_cyc, output int cyc, output bit hit, output bit to_seen);
    cyc     = 0;
    hit     = 1'b0;
    to_seen = 1'b0;
    while (!hit && cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (timeout) to_seen = 1'b1;
      if (period_valid) hit = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_period",  int'(period),       0);
    chk("rst_valid",   int'(period_valid), 0);
    chk("rst_locked",  int'(locked),       0);
    chk("rst_timeout", int'(timeout),      0);

    // Steady 8-cycle clock: first report needs two rises
    reset  = 1'b0;
    en     = 1'b1;
    gen_hi = 4;
    gen_lo = 4;
    gen_on = 1'b1;
    wait_valid(40, n, found, tos);
    chk("t1_found",   int'(found), 1);
    chk("t1_latency", int'(n >= 10 && n <= 13), 1);
    chk("t1_period",  int'(period), 8);
    chk("t1_locked",  int'(locked), 1);
    for (int i = 0; i < 3; i++) begin
      wait_valid(20, n, found, tos);
      chk("t1_interval",  n, 8);
      chk("t1_period_rp", int'(period), 8);
      chk("t1_locked_rp", int'(locked), 1);
    end

    // Rate change 8 -> 20
    gen_hi = 10;
    gen_lo = 10;
    wait_valid(20, n, found, tos);
    chk("t2_old_period", int'(period), 8);
    wait_valid(40, n, found, tos);
    chk("t2_found",    int'(found), 1);
    chk("t2_interval", n, 20);
    chk("t2_period",   int'(period), 20);
    chk("t2_locked",   int'(locked), 1);

    // clk_in stuck low: timeout 63 cycles after the last reported rise
    gen_level = 1'b0;
    gen_on    = 1'b0;
    first_to  = 0;
    saw_valid = 1'b0;
    for (int k = 1; k <= 80 && first_to == 0; k++) begin
      @(negedge clk);
      if (period_valid) saw_valid = 1'b1;
      if (timeout) first_to = k;
    end
    chk("t3_to_cycle", first_to, 63);
    chk("t3_no_valid", int'(saw_valid), 0);
    chk("t3_locked",   int'(locked), 0);
    chk("t3_timeout",  int'(timeout), 1);
    repeat (10) @(negedge clk);
    chk("t3_to_level", int'(timeout), 1);

    // Rises exactly 63 apart: saturated count still reported
    gen_hi = 30;
    gen_lo = 33;
    gen_on = 1'b1;
    wait_valid(200, n, found, tos);
    chk("t4_found",    int'(found), 1);
    chk("t4_to_held",  int'(tos), 1);
    chk("t4_period",   int'(period), 63);
    chk("t4_timeout",  int'(timeout), 0);
    chk("t4_locked",   int'(locked), 1);
    wait_valid(80, n, found, tos);
    chk("t4_interval", n, 63);
    chk("t4_no_to",    int'(tos), 0);
    chk("t4_period2",  int'(period), 63);

    // Drop enable while measuring, then re-enable
    gen_hi = 4;
    gen_lo = 4;
    wait_valid(80, n, found, tos);
    chk("t5_old_period", int'(period), 63);
    wait_valid(20, n, found, tos);
    chk("t5_period",   int'(period), 8);
    chk("t5_locked",   int'(locked), 1);
    en = 1'b0;
    @(negedge clk);
    chk("t5_off_locked",  int'(locked), 0);
    chk("t5_off_timeout", int'(timeout), 0);
    chk("t5_off_period",  int'(period), 8);
    chk("t5_off_valid",   int'(period_valid), 0);
    wait_valid(20, n, found, tos);
    chk("t5_off_no_valid", int'(found), 0);
    en = 1'b1;
    wait_valid(40, n, found, tos);
    chk("t5_re_found",   int'(found), 1);
    chk("t5_re_latency", int'(n >= 10 && n <= 17), 1);
    chk("t5_re_period",  int'(period), 8);

    // Reset during measurement, applied in the low phase of clk_in
    guard = 0;
    while (clk_in !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    while (clk_in !== 1'b0 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    chk("t6_phase_found", int'(clk_in), 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_period",  int'(period), 0);
    chk("t6_rst_valid",   int'(period_valid), 0);
    chk("t6_rst_locked",  int'(locked), 0);
    chk("t6_rst_timeout", int'(timeout), 0);
    reset = 1'b0;
    wait_valid(40, n, found, tos);
    chk("t6_found",   int'(found), 1);
    chk("t6_latency", int'(n >= 10 && n <= 16), 1);
    chk("t6_period",  int'(period), 8);
    chk("t6_locked",  int'(locked), 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_clk_period_meter
